// File: rtl/arilla_arbiter_if.sv
// arilla_bus_if: shared word-addressed bus between the arbiter (master) and the devices.
// Devices drive hit and data_ptc; intercept flags which device claimed the response.
interface arilla_bus_if #(
    parameter int AddressWidth = 30,
    parameter int DataWidth    = 32
);
    logic [AddressWidth-1:0] address;
    logic [DataWidth-1:0]    data_ctp;
    logic [DataWidth-1:0]    data_ptc;
    logic [DataWidth/8-1:0]  byte_enable;
    logic                    read;
    logic                    write;
    logic                    hit;
    logic                    intercept;

    modport master (
        output address, data_ctp, byte_enable, read, write,
        input  hit, data_ptc
    );

    modport device (
        input  address, data_ctp, byte_enable, read, write,
        output hit, data_ptc, intercept
    );
endinterface

// File: rtl/arilla_arbiter.sv
// arilla_arbiter: two-port to one-bus arbiter, one transaction per cycle, responses one cycle later.
// Optional ARILLA_ARBITER_ROUND_ROBIN_EN replaces fixed port-0 priority with round-robin.
module arilla_arbiter #(
    parameter int AddressWidth = 30,
    parameter int DataWidth    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [AddressWidth-1:0] p0_addr,
    input  logic [DataWidth/8-1:0]  p0_be,
    input  logic [DataWidth-1:0]    p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [DataWidth-1:0]    p0_rdata,
    output logic                    p0_err,

    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [AddressWidth-1:0] p1_addr,
    input  logic [DataWidth/8-1:0]  p1_be,
    input  logic [DataWidth-1:0]    p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [DataWidth-1:0]    p1_rdata,
    output logic                    p1_err,

    arilla_bus_if.master            bus_interface
);

    typedef struct packed {
        logic valid;
        logic port;
        logic rd;
        logic hit;
    } pending_t;

    pending_t pending;
    logic     sel_p1;
    logic     grant_any;
    logic     sel_we;
    logic     rsp_live;
    logic     rsp_rvalid;
    logic     rsp_err;

`ifdef ARILLA_ARBITER_ROUND_ROBIN_EN
    // prio_p1 names the port that wins the next tie: the one not granted most recently.
    logic prio_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_p1 <= 1'b0;
        end else if (grant_any) begin
            prio_p1 <= ~sel_p1;
        end
    end

    assign sel_p1 = p1_req & (~p0_req | prio_p1);
`else
    assign sel_p1 = p1_req & ~p0_req;
`endif

    // Gating with rst_n keeps gnt and the bus strobes low during reset, not only after it.
    assign grant_any = (p0_req | p1_req) & rst_n;
    assign p0_gnt    = grant_any & ~sel_p1;
    assign p1_gnt    = grant_any &  sel_p1;
    assign sel_we    = sel_p1 ? p1_we : p0_we;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bus_interface.address     = '0;
        bus_interface.data_ctp    = '0;
        bus_interface.byte_enable = '0;
        bus_interface.read        = 1'b0;
        bus_interface.write       = 1'b0;
        if (grant_any) begin
            bus_interface.address     = sel_p1 ? p1_addr  : p0_addr;
            bus_interface.data_ctp    = sel_p1 ? p1_wdata : p0_wdata;
            bus_interface.byte_enable = sel_p1 ? p1_be    : p0_be;
            bus_interface.read        = ~sel_we;
            bus_interface.write       = sel_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending.valid <= grant_any;
            pending.port  <= sel_p1;
            pending.rd    <= ~sel_we;
            pending.hit   <= bus_interface.hit;
        end
    end

    // A response still in flight when reset asserts is suppressed, then cleared at the edge.
    assign rsp_live   = pending.valid & rst_n;
    assign rsp_rvalid = rsp_live & pending.rd & pending.hit;
    assign rsp_err    = rsp_live & ~pending.hit;

    assign p0_rvalid = rsp_rvalid & ~pending.port;
    assign p1_rvalid = rsp_rvalid &  pending.port;
    assign p0_err    = rsp_err    & ~pending.port;
    assign p1_err    = rsp_err    &  pending.port;
    assign p0_rdata  = p0_rvalid ? bus_interface.data_ptc : '0;
    assign p1_rdata  = p1_rvalid ? bus_interface.data_ptc : '0;

endmodule

// File: tb/tb_arilla_arbiter.sv
// Directed self-checking bench for arilla_arbiter; expectations follow ARILLA_ARBITER_ROUND_ROBIN_EN.
module tb_arilla_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [3:0]    p0_be, p1_be;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    arilla_bus_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

    arilla_arbiter #(.AddressWidth(AW), .DataWidth(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .bus_interface(bus)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_be = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
        bus.hit = 1'b0; bus.data_ptc = '0; bus.intercept = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 30'h5; p1_req = 1'b1;
        settle();
        n_cmp++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_gnt: got %b%b want 00", p0_gnt, p1_gnt); end
        n_cmp++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin n_bad++; $display("FAIL reset_rw: got r=%b w=%b want 0 0", bus.read, bus.write); end
        n_cmp++; if (bus.address !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.address); end
        next_cycle();
        settle();
        n_cmp++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_rsp: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
        next_cycle();
        rst_n = 1'b1;
        settle();
        n_cmp++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_release_rsp: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
    endtask

    task automatic test_p1_read();
        next_cycle();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 30'h10; bus.hit = 1'b1;
        settle();
        n_cmp++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin n_bad++; $display("FAIL p1rd_gnt: got p0=%b p1=%b want 0 1", p0_gnt, p1_gnt); end
        n_cmp++; if (bus.read !== 1'b1 || bus.write !== 1'b0 || bus.address !== 30'h10) begin n_bad++; $display("FAIL p1rd_bus: got r=%b w=%b a=%h want 1 0 10", bus.read, bus.write, bus.address); end
        next_cycle();
        bus.data_ptc = 32'hDEADBEEF; bus.intercept = 1'b1;
        settle();
        n_cmp++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL p1rd_data: got v=%b d=%h want 1 deadbeef", p1_rvalid, p1_rdata); end
        n_cmp++; if ({p0_rvalid, p0_err, p1_err} !== 3'b0 || p0_rdata !== '0) begin n_bad++; $display("FAIL p1rd_quiet: got %b d=%h want 000 0", {p0_rvalid, p0_err, p1_err}, p0_rdata); end
        n_cmp++; if (bus.read !== 1'b0 || bus.address !== '0) begin n_bad++; $display("FAIL idle_bus: got r=%b a=%h want 0 0", bus.read, bus.address); end
    endtask

    task automatic test_p0_write();
        next_cycle();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 30'h4; p0_be = 4'h3; p0_wdata = 32'h12345678; bus.hit = 1'b1;
        settle();
        n_cmp++; if (p0_gnt !== 1'b1 || bus.write !== 1'b1 || bus.read !== 1'b0) begin n_bad++; $display("FAIL p0wr_ctl: got g=%b w=%b r=%b want 1 1 0", p0_gnt, bus.write, bus.read); end
        n_cmp++; if (bus.byte_enable !== 4'h3 || bus.data_ctp !== 32'h12345678 || bus.address !== 30'h4) begin n_bad++; $display("FAIL p0wr_bus: got be=%h d=%h a=%h want 3 12345678 4", bus.byte_enable, bus.data_ctp, bus.address); end
        next_cycle();
        bus.data_ptc = 32'hAAAA5555;
        settle();
        n_cmp++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0 || p0_rdata !== '0) begin n_bad++; $display("FAIL p0wr_rsp: got %b d=%h want 0000 0", {p0_rvalid, p0_err, p1_rvalid, p1_err}, p0_rdata); end
    endtask

    task automatic test_err();
        next_cycle();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 30'h3FFFFFFF; bus.hit = 1'b0;
        settle();
        n_cmp++; if (p0_gnt !== 1'b1 || bus.address !== 30'h3FFFFFFF) begin n_bad++; $display("FAIL err_gnt: got g=%b a=%h want 1 3fffffff", p0_gnt, bus.address); end
        next_cycle();
        bus.data_ptc = 32'h0BAD0BAD;
        settle();
        n_cmp++; if (p0_err !== 1'b1 || p0_rvalid !== 1'b0 || p1_err !== 1'b0 || p0_rdata !== '0) begin n_bad++; $display("FAIL err_rsp: got e=%b v=%b e1=%b d=%h want 1 0 0 0", p0_err, p0_rvalid, p1_err, p0_rdata); end
        next_cycle();
        settle();
        n_cmp++; if (p0_err !== 1'b0) begin n_bad++; $display("FAIL err_oneshot: got %b want 0", p0_err); end
    endtask

    task automatic test_both();
        logic exp_p1;
        logic prev_p1;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        prev_p1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            p0_req = 1'b1; p0_addr = 30'h100 + AW'(i);
            p1_req = 1'b1; p1_addr = 30'h200 + AW'(i);
            bus.hit = 1'b1; bus.data_ptc = 32'hC0DE0000 + DW'(i);
`ifdef ARILLA_ARBITER_ROUND_ROBIN_EN
            exp_p1 = (i % 2) == 1;
`else
            exp_p1 = 1'b0;
`endif
            settle();
            n_cmp++; if (p1_gnt !== exp_p1 || p0_gnt !== !exp_p1) begin n_bad++; $display("FAIL both_gnt%0d: got p0=%b p1=%b want p1=%b", i, p0_gnt, p1_gnt, exp_p1); end
            n_cmp++; if (bus.address !== (exp_p1 ? 30'h200 + AW'(i) : 30'h100 + AW'(i))) begin n_bad++; $display("FAIL both_addr%0d: got %h", i, bus.address); end
            if (i > 0) begin
                n_cmp++; if (p0_rvalid !== !prev_p1 || p1_rvalid !== prev_p1 || (prev_p1 ? p1_rdata : p0_rdata) !== 32'hC0DE0000 + DW'(i)) begin n_bad++; $display("FAIL both_rsp%0d: got v0=%b v1=%b d0=%h d1=%h", i, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata); end
            end
            prev_p1 = exp_p1;
        end
        next_cycle();
        bus.data_ptc = 32'hC0DE0004;
        settle();
        n_cmp++; if (p0_rvalid !== !prev_p1 || p1_rvalid !== prev_p1 || (prev_p1 ? p1_rdata : p0_rdata) !== 32'hC0DE0004) begin n_bad++; $display("FAIL both_last: got v0=%b v1=%b d0=%h d1=%h", p0_rvalid, p1_rvalid, p0_rdata, p1_rdata); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        p0_req = 1'b1; p0_addr = 30'h20; bus.hit = 1'b1;
        settle();
        n_cmp++; if (p0_gnt !== 1'b1 || bus.address !== 30'h20) begin n_bad++; $display("FAIL b2b_gnt0: got g=%b a=%h want 1 20", p0_gnt, bus.address); end
        next_cycle();
        p0_req = 1'b1; p0_addr = 30'h21; bus.hit = 1'b1; bus.data_ptc = 32'hA0000020;
        settle();
        n_cmp++; if (p0_gnt !== 1'b1 || p0_rvalid !== 1'b1 || p0_rdata !== 32'hA0000020) begin n_bad++; $display("FAIL b2b_rsp0: got g=%b v=%b d=%h want 1 1 a0000020", p0_gnt, p0_rvalid, p0_rdata); end
        next_cycle();
        bus.data_ptc = 32'hA0000021;
        settle();
        n_cmp++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hA0000021) begin n_bad++; $display("FAIL b2b_rsp1: got v=%b d=%h want 1 a0000021", p0_rvalid, p0_rdata); end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        p0_req = 1'b1; p0_addr = 30'h30; bus.hit = 1'b1;
        settle();
        n_cmp++; if (p0_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid_gnt: got %b want 1", p0_gnt); end
        next_cycle();
        rst_n = 1'b0; p1_req = 1'b1; bus.data_ptc = 32'h55555555;
        settle();
        n_cmp++; if (p0_rvalid !== 1'b0 || p0_err !== 1'b0 || p0_rdata !== '0) begin n_bad++; $display("FAIL rstmid_rsp: got v=%b e=%b d=%h want 0 0 0", p0_rvalid, p0_err, p0_rdata); end
        n_cmp++; if (bus.read !== 1'b0 || bus.write !== 1'b0 || p1_gnt !== 1'b0) begin n_bad++; $display("FAIL rstmid_bus: got r=%b w=%b g1=%b want 0 0 0", bus.read, bus.write, p1_gnt); end
        next_cycle();
        rst_n = 1'b1; bus.data_ptc = 32'h66666666;
        settle();
        n_cmp++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin n_bad++; $display("FAIL rstmid_after: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
        next_cycle();
        settle();
        n_cmp++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin n_bad++; $display("FAIL rstmid_after2: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_be = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
        bus.hit = 1'b0; bus.data_ptc = '0; bus.intercept = 1'b0;
        test_reset();
        test_p1_read();
        test_p0_write();
        test_err();
        test_both();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
